// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end.
// The queue stores each instruction together with its byte PC so decode
// never has to reconstruct addresses after a redirect or an unaligned start.
package fetch_pkg;

   localparam int INS_W       = 32;
   localparam int FETCH_BYTES = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RESP
   } fetch_state_e;

   typedef struct packed {
      logic [INS_W-1:0] ins;
      logic [31:0]      pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue: writes two entries at once (or none), exposes
// the two oldest entries combinationally and retires 0..2 per cycle.
// A flush empties it in one cycle. The caller guarantees room before a push
// and never takes more than the number of occupied entries.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  fetch_entry_t               push0_i,
   input  fetch_entry_t               push1_i,
   input  logic [1:0]                 take_i,
   output fetch_entry_t               head0_o,
   output fetch_entry_t               head1_o,
   output logic [1:0]                 avail_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t    mem_q [DEPTH];
   logic [PW-1:0]   rdPtr_q;
   logic [PW-1:0]   wrPtr_q;
   logic [CW-1:0]   count_q;
   logic            pushEff;

   assign pushEff = push_i && !flush_i;

   // Entry storage needs no reset; stale contents are masked by the count.
   always_ff @(posedge clk) begin
      if (pushEff) begin
         mem_q[wrPtr_q]           <= push0_i;
         mem_q[wrPtr_q + PW'(1)]  <= push1_i;
      end
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_q + PW'(take_i);
         wrPtr_q <= wrPtr_q + (pushEff ? PW'(2) : PW'(0));
         count_q <= count_q + (pushEff ? CW'(2) : CW'(0)) - CW'(take_i);
      end
   end

   // Head window reads are zero-latency; empty slots read as zero.
   always_comb begin
      head0_o = '0;
      head1_o = '0;
      avail_o = 2'd0;
      if (count_q >= CW'(1)) begin
         head0_o = mem_q[rdPtr_q];
         avail_o = 2'd1;
      end
      if (count_q >= CW'(2)) begin
         head1_o = mem_q[rdPtr_q + PW'(1)];
         avail_o = 2'd2;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch controller: owns the PC, strobes the dual-word instruction memory,
// captures each {ins0, ins1} pair into the queue and serves decode.
// A redirect flushes everything and restarts fetch at the new address.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int          QUEUE_DEPTH = 8,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          mem_req,
   output logic [31:0]                   mem_pc,
   input  logic [INS_W-1:0]              mem_ins0,
   input  logic [INS_W-1:0]              mem_ins1,
   input  logic                          halt,
   input  logic                          redirect_valid,
   input  logic [31:0]                   redirect_pc,
   output logic [1:0]                    dec_avail,
   output logic [INS_W-1:0]              dec_ins0,
   output logic [INS_W-1:0]              dec_ins1,
   output logic [31:0]                   dec_pc0,
   output logic [31:0]                   dec_pc1,
   input  logic [1:0]                    dec_take,
   output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic          push;
   logic [1:0]    takeEff;
   fetch_entry_t  push0, push1, head0, head1;

   // A response is dropped if a redirect lands in the same cycle.
   assign push  = (state_q == S_RESP) && !redirect_valid;
   assign push0 = '{ins: mem_ins0, pc: pc_q};
   assign push1 = '{ins: mem_ins1, pc: pc_q + 32'd4};

   // Decode may not over-take; clamp defensively, and ignore it on redirect.
   always_comb begin
      takeEff = dec_take;
      if (dec_take > dec_avail) begin
         takeEff = dec_avail;
      end
      if (redirect_valid) begin
         takeEff = 2'd0;
      end
   end

   // State and PC registers; reset beats redirect and halt.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next-state logic. From S_RESP the pair being captured is counted as
   // already occupying two slots, so the next request still has room.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         S_IDLE: begin
            if (!halt && queue_count <= CW'(QUEUE_DEPTH - 2)) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            pc_d = pc_q + 32'(FETCH_BYTES);
            if (!halt && queue_count <= CW'(QUEUE_DEPTH - 4)) begin
               state_d = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (redirect_valid) begin
         state_d = S_IDLE;
         pc_d    = redirect_pc;
      end
   end

   assign mem_req = (state_q == S_REQ);
   assign mem_pc  = pc_q;

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) uQueue (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_valid),
      .push_i  (push),
      .push0_i (push0),
      .push1_i (push1),
      .take_i  (takeEff),
      .head0_o (head0),
      .head1_o (head1),
      .avail_o (dec_avail),
      .count_o (queue_count)
   );

   assign dec_ins0 = head0.ins;
   assign dec_ins1 = head1.ins;
   assign dec_pc0  = head0.pc;
   assign dec_pc1  = head1.pc;

   // Decode consuming more than is presented is a protocol error upstream.
   assert property (@(posedge clk) disable iff (rst || redirect_valid)
                    dec_take <= dec_avail)
      else $error("dec_take %0d exceeds dec_avail %0d", dec_take, dec_avail);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a combinational memory model.
module tb_fetch_controller;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_pc;
   logic [31:0] mem_ins0;
   logic [31:0] mem_ins1;
   logic        halt;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [1:0]  dec_avail;
   logic [31:0] dec_ins0;
   logic [31:0] dec_ins1;
   logic [31:0] dec_pc0;
   logic [31:0] dec_pc1;
   logic [1:0]  dec_take;
   logic [3:0]  queue_count;

   int errors;
   int checks;
   int reqSeen;

   fetch_controller #(
      .QUEUE_DEPTH (8),
      .RESET_PC    (32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req        (mem_req),
      .mem_pc         (mem_pc),
      .mem_ins0       (mem_ins0),
      .mem_ins1       (mem_ins1),
      .halt           (halt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_avail      (dec_avail),
      .dec_ins0       (dec_ins0),
      .dec_ins1       (dec_ins1),
      .dec_pc0        (dec_pc0),
      .dec_pc1        (dec_pc1),
      .dec_take       (dec_take),
      .queue_count    (queue_count)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents are a fixed function of the byte address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   assign mem_ins0 = memWord(mem_pc);
   assign mem_ins1 = memWord(mem_pc + 32'd4);

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic h, input logic rv, input logic [31:0] rpc, input logic [1:0] tk);
      halt           = h;
      redirect_valid = rv;
      redirect_pc    = rpc;
      dec_take       = tk;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      errors = 0;
      checks = 0;

      // Reset state
      doReset();
      checkOutput("rst_req", mem_req, 0);
      checkOutput("rst_pc", mem_pc, 32'h0);
      checkOutput("rst_avail", dec_avail, 0);
      checkOutput("rst_count", queue_count, 0);
      checkOutput("rst_ins0", dec_ins0, 0);
      checkOutput("rst_pc0", dec_pc0, 0);

      // Test 1: streaming with decode taking every available pair
      tick();
      checkOutput("t1_req1", mem_req, 1);
      checkOutput("t1_mpc1", mem_pc, 32'h0);
      tick();
      checkOutput("t1_resp", mem_req, 0);
      tick();
      checkOutput("t1_req3", mem_req, 1);
      checkOutput("t1_mpc3", mem_pc, 32'h8);
      checkOutput("t1_avail", dec_avail, 2);
      checkOutput("t1_pc0a", dec_pc0, 32'h0);
      checkOutput("t1_pc1a", dec_pc1, 32'h4);
      checkOutput("t1_ins0a", dec_ins0, memWord(32'h0));
      checkOutput("t1_ins1a", dec_ins1, memWord(32'h4));
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd2);
      tick();
      checkOutput("t1_drain", queue_count, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
      tick();
      checkOutput("t1_req5", mem_req, 1);
      checkOutput("t1_mpc5", mem_pc, 32'h10);
      checkOutput("t1_pc0b", dec_pc0, 32'h8);
      checkOutput("t1_pc1b", dec_pc1, 32'hC);

      // Test 2: fill the queue with no draining
      doReset();
      reqSeen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (mem_req) reqSeen++;
      end
      checkOutput("t2_reqs", reqSeen, 4);
      checkOutput("t2_full", queue_count, 8);
      checkOutput("t2_noreq", mem_req, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd1);
      tick();
      checkOutput("t2_cnt7", queue_count, 7);
      checkOutput("t2_pc0", dec_pc0, 32'h4);
      checkOutput("t2_pc1", dec_pc1, 32'h8);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
      tick();
      checkOutput("t2_noreq7", mem_req, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd1);
      tick();
      checkOutput("t2_cnt6", queue_count, 6);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
      tick();
      checkOutput("t2_req6", mem_req, 1);
      checkOutput("t2_mpc6", mem_pc, 32'h20);

      // Test 3: unaligned redirect target
      doReset();
      applyStimulus(1'b0, 1'b1, 32'h6, 2'd0);
      tick();
      checkOutput("t3_idle", mem_req, 0);
      checkOutput("t3_mpc", mem_pc, 32'h6);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
      tick();
      checkOutput("t3_req", mem_req, 1);
      checkOutput("t3_mpc6", mem_pc, 32'h6);
      tick();
      tick();
      checkOutput("t3_mpc14", mem_pc, 32'hE);
      checkOutput("t3_pc0", dec_pc0, 32'h6);
      checkOutput("t3_pc1", dec_pc1, 32'hA);
      checkOutput("t3_ins1", dec_ins1, memWord(32'hA));
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd2);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
      tick();
      checkOutput("t3_pc2", dec_pc0, 32'hE);
      checkOutput("t3_pc3", dec_pc1, 32'h12);

      // Test 4: redirect while a response is being captured, 3 queued
      doReset();
      for (int i = 0; i < 5; i++) tick();
      checkOutput("t4_cnt4", queue_count, 4);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd1);
      tick();
      checkOutput("t4_cnt3", queue_count, 3);
      applyStimulus(1'b0, 1'b1, 32'h100, 2'd1);
      tick();
      checkOutput("t4_flush", queue_count, 0);
      checkOutput("t4_avail", dec_avail, 0);
      checkOutput("t4_pc0z", dec_pc0, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
      tick();
      checkOutput("t4_req", mem_req, 1);
      checkOutput("t4_mpc", mem_pc, 32'h100);

      // Test 5: halt raised during the request cycle
      doReset();
      tick();
      checkOutput("t5_req", mem_req, 1);
      applyStimulus(1'b1, 1'b0, 32'h0, 2'd0);
      tick();
      tick();
      checkOutput("t5_cap", queue_count, 2);
      reqSeen = 0;
      for (int i = 0; i < 6; i++) begin
         if (mem_req) reqSeen++;
         tick();
      end
      checkOutput("t5_held", reqSeen, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
      tick();
      checkOutput("t5_resume", mem_req, 1);
      checkOutput("t5_mpc", mem_pc, 32'h8);

      // Test 6: PC wrap and reset in the middle of a fetch
      doReset();
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 2'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd0);
      tick();
      checkOutput("t6_mpcTop", mem_pc, 32'hFFFF_FFF8);
      tick();
      tick();
      checkOutput("t6_wrap", mem_pc, 32'h0);
      checkOutput("t6_pc1", dec_pc1, 32'hFFFF_FFFC);
      checkOutput("t6_reqw", mem_req, 1);
      rst = 1'b1;
      tick();
      checkOutput("t6_rreq", mem_req, 0);
      checkOutput("t6_rpc", mem_pc, 32'h0);
      checkOutput("t6_rcnt", queue_count, 0);
      checkOutput("t6_ravail", dec_avail, 0);
      rst = 1'b0;
      tick();
      tick();
      tick();
      checkOutput("t6_after", queue_count, 2);
      checkOutput("t6_apc0", dec_pc0, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
